instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Pipelined instruction decode stage sitting between instruction fetch and the datapath.
//  - Input: fetched 32-bit MIPS words on a valid/ready stream.
//  - Output: register fields, extended immediate, jump target and the ControlBus field set
//    (rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc, alu_ctrl).
//  - Includes a 2-entry skid buffer, so both handshakes are fully registered.
// PARAMETERS
//  DATA_W   32  instruction, PC and immediate width
//  DEPTH    2   skid-buffer entries; only 2 is supported
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  flush        in   1   discard all buffered entries (branch/jump redirect)
//  in_valid     in   1   fetch word valid
//  in_ready     out  1   stage can accept a word
//  in_instr     in   32  instruction word
//  in_pc        in   32  PC of in_instr
//  out_valid    out  1   decoded entry valid
//  out_ready    in   1   datapath accepts the entry
//  out_rs/rt/rd out  5   register fields [25:21]/[20:16]/[15:11]
//  out_shamt    out  5   instr[10:6]
//  out_imm      out  32  sign-extended imm; zero-extended for ANDI/ORI; imm<<16 for LUI
//  out_jtarget  out  32  {pc_plus4[31:28], instr[25:0], 2'b00}
//  out_pc_plus4 out  32  in_pc + 4, wrapping mod 2^32
//  out_branch   out  1   BEQ/BNE; the datapath resolves it with zero
//  out_bne      out  1   1 = BNE, 0 = BEQ
//  out_rf_we 1 | out_sel_wa 2 | out_sel_alu_b 1 | out_dmem_we 1 | out_sel_result 2
//  out_sel_pc 2 | out_alu_ctrl 4   ControlBus encodings
//  out_illegal  out  1   unrecognised opcode/funct (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every output is 0; buffer is empty; in_ready is 1 on the first cycle after reset release.
//  - Handshakes:
//    - Transfer occurs when valid && ready; out_valid never drops without a transfer.
//    - Output fields are stable while out_valid && !out_ready.
//  - Latency: 1 cycle from in transfer to out_valid when the buffer is empty.
//    Throughput is 1/cycle while out_ready = 1.
//  - Skid buffer:
//    - in_ready = (count < 2), registered.
//    - Simultaneous push and pop leaves count unchanged; order is preserved (FIFO).
//    - Push is ignored when full; the upstream has in_ready = 0, so no data is lost.
//  - Decode:
//    - Combinational on push; the registered result is stored per entry.
//    - No Z values: don't-care fields drive 0.
//  - Control table:
//    | Instruction       | rf_we | sel_wa | alu_b | dmem_we | sel_result | sel_pc | alu_ctrl       |
//    |-------------------|-------|--------|-------|---------|------------|--------|----------------|
//    | LW                | 1     | 00     | 1     | 0       | 00         | 00     | ADDI(0)        |
//    | SW                | 0     | 00     | 1     | 1       | 01         | 00     | ADDI(0)        |
//    | ADDI/ADDIU        | 1     | 00     | 1     | 0       | 01         | 00     | ADDI(0)        |
//    | J                 | 0     | —      | —     | 0       | —          | 10     | —              |
//    | JAL               | 1     | 10     | —     | 0       | 10         | 10     | —              |
//    | BEQ/BNE           | 0     | —      | 0     | 0       | —          | 00     | SUBI(1)        |
//    | R-type            | 1     | 01     | 0     | 0       | 01         | 00     | from funct     |
//    | JR                | 0     | —      | —     | 0       | —          | 11     | JR(11)         |
//    (— = driven 0.) BEQ/BNE also assert out_branch.
//  - R-type funct -> alu_ctrl: ADD/ADDU 2, SUB/SUBU 3, AND 4, OR 5, SLT 6, MULTU 7, DIVU 8, MFHI 9, MFLO 10.
//  - Illegal or unlisted encodings decode as NOP: all write enables 0, sel_pc 00.
//  - flush: count <- 0 and out_valid <- 0 next cycle; a same-cycle push is dropped.
//    flush has priority over push and pop.
//  - Reset mid-operation: immediate return to the reset state; in-flight entries are lost.
// CONFIGURATION
//  - DECODE_ILLEGAL_TRAP_EN defined:
//    - An illegal encoding is decoded as a NOP with out_illegal = 1.
//    - After pushing it, the stage holds in_ready = 0 until flush or reset; that entry still drains normally.
//  - Not defined: out_illegal is tied 0, illegal encodings flow through as NOPs, no stall.
// STRUCTURE
//  - Package decode_types:
//    - decoded_t packed struct (fields + control).
//    - Opcode/funct localparams matching global_types.
//    - NOP_CTRL constant.
//    - alu_ctrl encodings.
//  - Sub-module instr_field_decoder: purely combinational, 32-bit word + pc -> decoded_t.
//  - Top level holds the skid buffer, count and the trap state.
// TESTING
//  1. ADDI $9,$8,-4 = 0x2109FFFC, pc 0x100 ->
//     - next cycle: out_valid=1, rs=8, rt=9, imm=0xFFFFFFFC, pc_plus4=0x104
//     - control: rf_we=1, sel_alu_b=1, sel_result=01, alu_ctrl=0
//  2. ADD $3,$1,$2 = 0x00221820 -> rd=3, sel_wa=01, alu_ctrl=2, rf_we=1;
//     ORI 0x3421F000 -> imm=0x0000F000.
//  3. JAL 0x0C000010, pc 0x4000_0000 -> jtarget=0x40000040, sel_wa=10, sel_result=10, sel_pc=10.
//  4. Backpressure: 4 back-to-back words, out_ready=0 for 3 cycles ->
//     - 2 captured, in_ready=0, outputs stable
//     - after release, words emerge in order with no loss or duplication
//  5. flush with 2 entries buffered plus a concurrent push -> next cycle out_valid=0, in_ready=1,
//     dropped words never appear.
//  6. Opcode 0x3F with DECODE_ILLEGAL_TRAP_EN -> out_illegal=1, rf_we=dmem_we=0, in_ready=0 until flush;
//     without the macro -> NOP, in_ready stays 1.
//     Assert rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_types.sv
// Shared types for the instruction decode stage: opcode/funct codes, ALU control
// encodings, the per-entry decoded record and the all-zero NOP control word.
package decode_types;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08, FN_MFHI = 6'h10, FN_MFLO  = 6'h12, FN_MULTU = 6'h19,
                         FN_DIVU = 6'h1B, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB   = 6'h22,
                         FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR   = 6'h25, FN_SLT   = 6'h2A;

  localparam logic [3:0] ALU_ADDI = 4'd0, ALU_SUBI  = 4'd1, ALU_ADD  = 4'd2,  ALU_SUB  = 4'd3,
                         ALU_AND  = 4'd4, ALU_OR    = 4'd5, ALU_SLT  = 4'd6,  ALU_MULTU = 4'd7,
                         ALU_DIVU = 4'd8, ALU_MFHI  = 4'd9, ALU_MFLO = 4'd10, ALU_JR   = 4'd11;

  typedef struct packed {
    logic       rf_we;
    logic [1:0] sel_wa;
    logic       sel_alu_b;
    logic       dmem_we;
    logic [1:0] sel_result;
    logic [1:0] sel_pc;
    logic [3:0] alu_ctrl;
    logic       branch;
    logic       bne;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] jtarget;
    logic [DATA_W-1:0] pc_plus4;
    ctrl_t             ctrl;
    logic              illegal;
  } decoded_t;

  localparam ctrl_t NOP_CTRL = '0;

  // Returns {hit, alu_ctrl}; hit=0 for functs with no ALU mapping.
  function automatic logic [4:0] alu_from_funct(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU: return {1'b1, ALU_ADD};
      FN_SUB, FN_SUBU: return {1'b1, ALU_SUB};
      FN_AND:          return {1'b1, ALU_AND};
      FN_OR:           return {1'b1, ALU_OR};
      FN_SLT:          return {1'b1, ALU_SLT};
      FN_MULTU:        return {1'b1, ALU_MULTU};
      FN_DIVU:         return {1'b1, ALU_DIVU};
      FN_MFHI:         return {1'b1, ALU_MFHI};
      FN_MFLO:         return {1'b1, ALU_MFLO};
      default:         return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_decoder.sv
// Purely combinational MIPS word decoder: instruction + PC -> decoded_t record.
module instr_field_decoder
  import decode_types::*;
(
  input  logic [DATA_W-1:0] i_instr,
  input  logic [DATA_W-1:0] i_pc,
  output decoded_t          o_dec
);

  logic [5:0]        w_op;
  logic [5:0]        w_fn;
  logic [DATA_W-1:0] w_pc4;
  logic [4:0]        w_alu;

  assign w_op  = i_instr[31:26];
  assign w_fn  = i_instr[5:0];
  assign w_pc4 = i_pc + 32'd4;
  assign w_alu = alu_from_funct(w_fn);

  always_comb begin
    o_dec          = '0;
    o_dec.rs       = i_instr[25:21];
    o_dec.rt       = i_instr[20:16];
    o_dec.rd       = i_instr[15:11];
    o_dec.shamt    = i_instr[10:6];
    o_dec.pc_plus4 = w_pc4;
    o_dec.jtarget  = {w_pc4[31:28], i_instr[25:0], 2'b00};
    case (w_op)
      OP_ANDI, OP_ORI: o_dec.imm = {16'h0, i_instr[15:0]};
      OP_LUI:          o_dec.imm = {i_instr[15:0], 16'h0};
      default:         o_dec.imm = {{16{i_instr[15]}}, i_instr[15:0]};
    endcase

    o_dec.ctrl = NOP_CTRL;
    case (w_op)
      OP_LW: begin
        o_dec.ctrl.rf_we     = 1'b1;
        o_dec.ctrl.sel_alu_b = 1'b1;
      end
      OP_SW: begin
        o_dec.ctrl.sel_alu_b  = 1'b1;
        o_dec.ctrl.dmem_we    = 1'b1;
        o_dec.ctrl.sel_result = 2'b01;
      end
      OP_ADDI, OP_ADDIU: begin
        o_dec.ctrl.rf_we      = 1'b1;
        o_dec.ctrl.sel_alu_b  = 1'b1;
        o_dec.ctrl.sel_result = 2'b01;
      end
      OP_J:   o_dec.ctrl.sel_pc = 2'b10;
      OP_JAL: begin
        o_dec.ctrl.rf_we      = 1'b1;
        o_dec.ctrl.sel_wa     = 2'b10;
        o_dec.ctrl.sel_result = 2'b10;
        o_dec.ctrl.sel_pc     = 2'b10;
      end
      OP_BEQ, OP_BNE: begin
        o_dec.ctrl.branch   = 1'b1;
        o_dec.ctrl.bne      = (w_op == OP_BNE);
        o_dec.ctrl.alu_ctrl = ALU_SUBI;
      end
      // Known immediates with no control row: the immediate is produced, control stays NOP.
      OP_ANDI, OP_ORI, OP_LUI: o_dec.ctrl = NOP_CTRL;
      OP_RTYPE: begin
        if (w_fn == FN_JR) begin
          o_dec.ctrl.sel_pc   = 2'b11;
          o_dec.ctrl.alu_ctrl = ALU_JR;
        end else if (w_alu[4]) begin
          o_dec.ctrl.rf_we      = 1'b1;
          o_dec.ctrl.sel_wa     = 2'b01;
          o_dec.ctrl.sel_result = 2'b01;
          o_dec.ctrl.alu_ctrl   = w_alu[3:0];
        end else begin
          o_dec.illegal = 1'b1;
        end
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage with a 2-entry skid buffer of decoded records between fetch and datapath.
// Optional DECODE_ILLEGAL_TRAP_EN: flag illegal words and stall intake until flush/reset.
module instr_decode_stage
  import decode_types::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_jtarget,
  output logic [DATA_W-1:0] out_pc_plus4,
  output logic              out_branch,
  output logic              out_bne,
  output logic              out_rf_we,
  output logic [1:0]        out_sel_wa,
  output logic              out_sel_alu_b,
  output logic              out_dmem_we,
  output logic [1:0]        out_sel_result,
  output logic [1:0]        out_sel_pc,
  output logic [3:0]        out_alu_ctrl,
  output logic              out_illegal
);

  decoded_t   w_dec, w_store, w_head, w_out;
  decoded_t   r_mem [2];
  logic       r_wr_ptr, r_rd_ptr, r_in_ready, r_trap;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic       w_push, w_pop, w_trap_nxt;

  instr_field_decoder u_dec (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_dec   (w_dec)
  );

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_store = w_dec;
`else
  always_comb begin
    w_store         = w_dec;
    w_store.illegal = 1'b0;
  end
`endif

  assign w_push     = in_valid && r_in_ready && !flush;
  assign w_pop      = (r_cnt != 2'd0) && out_ready;
  assign w_cnt_nxt  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // With the illegal flag masked off in the default build, the trap can never set.
  assign w_trap_nxt = r_trap | (w_push & w_store.illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_trap     <= 1'b0;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_cnt      <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_trap     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_trap     <= w_trap_nxt;
      r_in_ready <= (w_cnt_nxt < 2'(DEPTH)) && !w_trap_nxt;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_store;
  end

  // Fields are forced to 0 while empty so stale entries never leak out.
  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_cnt != 2'd0);
  assign w_out     = out_valid ? w_head : '0;
  assign in_ready  = r_in_ready;

  assign out_rs         = w_out.rs;
  assign out_rt         = w_out.rt;
  assign out_rd         = w_out.rd;
  assign out_shamt      = w_out.shamt;
  assign out_imm        = w_out.imm;
  assign out_jtarget    = w_out.jtarget;
  assign out_pc_plus4   = w_out.pc_plus4;
  assign out_branch     = w_out.ctrl.branch;
  assign out_bne        = w_out.ctrl.bne;
  assign out_rf_we      = w_out.ctrl.rf_we;
  assign out_sel_wa     = w_out.ctrl.sel_wa;
  assign out_sel_alu_b  = w_out.ctrl.sel_alu_b;
  assign out_dmem_we    = w_out.ctrl.dmem_we;
  assign out_sel_result = w_out.ctrl.sel_result;
  assign out_sel_pc     = w_out.ctrl.sel_pc;
  assign out_alu_ctrl   = w_out.ctrl.alu_ctrl;
  assign out_illegal    = w_out.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; follows DECODE_ILLEGAL_TRAP_EN when defined.
module tb_instr_decode_stage;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_branch, out_bne, out_rf_we, out_sel_alu_b;
  logic        out_dmem_we, out_illegal;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [31:0] out_imm, out_jtarget, out_pc_plus4;
  logic [1:0]  out_sel_wa, out_sel_result, out_sel_pc;
  logic [3:0]  out_alu_ctrl;
  logic [14:0] ctl;
  int          errors = 0, checks = 0;

  assign ctl = {out_rf_we, out_sel_wa, out_sel_alu_b, out_dmem_we, out_sel_result,
                out_sel_pc, out_alu_ctrl, out_branch, out_bne};

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_imm(out_imm), .out_jtarget(out_jtarget), .out_pc_plus4(out_pc_plus4),
    .out_branch(out_branch), .out_bne(out_bne), .out_rf_we(out_rf_we),
    .out_sel_wa(out_sel_wa), .out_sel_alu_b(out_sel_alu_b), .out_dmem_we(out_dmem_we),
    .out_sel_result(out_sel_result), .out_sel_pc(out_sel_pc), .out_alu_ctrl(out_alu_ctrl),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL reset_vr: got %b want 00", {out_valid, in_ready}); end
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL reset_ctl: got %h want 0", ctl); end
    checks++; if ({out_imm, out_pc_plus4, out_jtarget, out_illegal} !== 97'd0) begin errors++; $display("FAIL reset_fields: got nonzero"); end
    rst_n = 1'b1;
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL reset_release: got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_addi;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h2109FFFC; in_pc = 32'h100;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    checks++; if ({out_rs, out_rt} !== {5'd8, 5'd9}) begin errors++; $display("FAIL addi_regs: got %0d,%0d want 8,9", out_rs, out_rt); end
    checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL addi_imm: got %h want fffffffc", out_imm); end
    checks++; if (out_pc_plus4 !== 32'h104) begin errors++; $display("FAIL addi_pc4: got %h want 104", out_pc_plus4); end
    checks++; if (ctl !== 15'b1_00_1_0_01_00_0000_0_0) begin errors++; $display("FAIL addi_ctl: got %b", ctl); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_rtype_ori;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h200;
    tick();
    in_instr = 32'h3421F000; in_pc = 32'h204;
    checks++; if ({out_valid, out_rs, out_rt, out_rd} !== {1'b1, 5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_regs: got %h", {out_valid, out_rs, out_rt, out_rd}); end
    checks++; if (ctl !== 15'b1_01_0_0_01_00_0010_0_0) begin errors++; $display("FAIL add_ctl: got %b", ctl); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_imm} !== {1'b1, 32'h0000F000}) begin errors++; $display("FAIL ori_imm: got %h want 0000f000", out_imm); end
    checks++; if (out_pc_plus4 !== 32'h208) begin errors++; $display("FAIL ori_pc4: got %h want 208", out_pc_plus4); end
    tick();
  endtask

  task automatic test_control_table;
    logic [31:0] vi [17];
    logic [14:0] ve [17];
    vi = '{32'h8C220008, 32'hAC220008, 32'h2422FFFF, 32'h10220004, 32'h14220004, 32'h08000010,
           32'h03E00008, 32'h00221821, 32'h00221822, 32'h00221823, 32'h00221824, 32'h00221825,
           32'h0022182A, 32'h00220019, 32'h0022001B, 32'h00001810, 32'h00221801};
    ve = '{15'b1_00_1_0_00_00_0000_0_0, 15'b0_00_1_1_01_00_0000_0_0, 15'b1_00_1_0_01_00_0000_0_0,
           15'b0_00_0_0_00_00_0001_1_0, 15'b0_00_0_0_00_00_0001_1_1, 15'b0_00_0_0_00_10_0000_0_0,
           15'b0_00_0_0_00_11_1011_0_0, 15'b1_01_0_0_01_00_0010_0_0, 15'b1_01_0_0_01_00_0011_0_0,
           15'b1_01_0_0_01_00_0011_0_0, 15'b1_01_0_0_01_00_0100_0_0, 15'b1_01_0_0_01_00_0101_0_0,
           15'b1_01_0_0_01_00_0110_0_0, 15'b1_01_0_0_01_00_0111_0_0, 15'b1_01_0_0_01_00_1000_0_0,
           15'b1_01_0_0_01_00_1001_0_0, 15'b0_00_0_0_00_00_0000_0_0};
    out_ready = 1'b1; in_pc = 32'h300;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_instr = vi[i];
      tick();
      checks++; if ({out_valid, ctl} !== {1'b1, ve[i]}) begin errors++; $display("FAIL ctl_vec%0d: got %b want %b", i, {out_valid, ctl}, {1'b1, ve[i]}); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_imm;
    logic [31:0] vi [4];
    logic [31:0] ve [4];
    vi = '{32'h2422FFFF, 32'h10220004, 32'h3022FFFF, 32'h3C011234};
    ve = '{32'hFFFFFFFF, 32'h00000004, 32'h0000FFFF, 32'h12340000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = vi[i];
      tick();
      checks++; if ({out_valid, out_imm} !== {1'b1, ve[i]}) begin errors++; $display("FAIL imm_vec%0d: got %h want %h", i, out_imm, ve[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_jal;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0C000010; in_pc = 32'h40000000;
    tick();
    in_instr = 32'h08000010; in_pc = 32'hFFFFFFFC;
    checks++; if ({out_jtarget, out_pc_plus4} !== {32'h40000040, 32'h40000004}) begin errors++; $display("FAIL jal_tgt: got %h %h", out_jtarget, out_pc_plus4); end
    checks++; if (ctl !== 15'b1_10_0_0_10_10_0000_0_0) begin errors++; $display("FAIL jal_ctl: got %b", ctl); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_jtarget, out_pc_plus4} !== {1'b1, 32'h00000040, 32'h0}) begin errors++; $display("FAIL pc_wrap: got %h %h", out_jtarget, out_pc_plus4); end
    tick();
  endtask

  task automatic test_backpressure;
    int     idx = 0;
    logic   acc, pop;
    logic [31:0] got [$];
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h20010010; in_pc = 32'h1000;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 3);
      if (c == 1 || c == 2) begin
        checks++; if ({out_valid, out_imm} !== {1'b1, 32'h10}) begin errors++; $display("FAIL bp_stable%0d: got %h want 10", c, out_imm); end
      end
      if (c == 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
        checks++; if ({out_valid, out_imm, out_pc_plus4} !== {1'b1, 32'h10, 32'h1004}) begin errors++; $display("FAIL bp_hold: got %h %h", out_imm, out_pc_plus4); end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) got.push_back(out_imm);
      tick();
      if (acc) idx++;
      if (idx < 4) begin
        in_instr = 32'h20010010 + 32'(idx); in_pc = 32'h1000 + 32'(4 * idx);
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== 32'h10 + 32'(k)) begin errors++; $display("FAIL bp_order%0d: got %h want %h", k, got[k], 32'h10 + 32'(k)); end
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h20010020;
    tick();
    in_instr = 32'h20010021;
    tick();
    in_instr = 32'h20010022; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_full: got %b want 01", {out_valid, in_ready}); end
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h20010023;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_imm} !== {1'b1, 32'h23}) begin errors++; $display("FAIL flush_after: got %h want 23", out_imm); end
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h20010024;
    tick();
    in_instr = 32'h20010025; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_push: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_illegal;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h500;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_rf_we, out_dmem_we, out_sel_pc} !== 5'b10000) begin errors++; $display("FAIL ill_nop: got %b", {out_valid, out_rf_we, out_dmem_we, out_sel_pc}); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    checks++; if ({out_illegal, in_ready} !== 2'b10) begin errors++; $display("FAIL ill_trap: got %b want 10", {out_illegal, in_ready}); end
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL ill_hold: got %b want 00", {out_valid, in_ready}); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_release: got %b want 1", in_ready); end
`else
    checks++; if ({out_illegal, in_ready} !== 2'b01) begin errors++; $display("FAIL ill_flow: got %b want 01", {out_illegal, in_ready}); end
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ill_nostall: got %b want 01", {out_valid, in_ready}); end
`endif
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h2109FFFC; in_pc = 32'h100;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready, ctl, out_imm, out_rs, out_rt} !== 59'd0) begin errors++; $display("FAIL ar_async: outputs not cleared"); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ar_release: got %b want 01", {out_valid, in_ready}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype_ori();
    test_control_table();
    test_imm();
    test_jal();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
